// File: rtl/token_run_encoder_pkg.sv
// Shared constants and the run-word layout for the token run-length encoder.
package token_run_pkg;

  localparam int TOKEN_LEN_W   = 8;
  localparam int TOKEN_MAX_RUN = 255;

  typedef struct packed {
    logic                   sat;
    logic [TOKEN_LEN_W-1:0] len;
  } run_word_t;

endpackage

// File: rtl/token_run_encoder_if.sv
// Valid/ready run-word channel between the encoder and its consumer.
interface token_run_if #(
  parameter int LEN_W = token_run_pkg::TOKEN_LEN_W
);
  logic             run_valid;
  logic             run_ready;
  logic [LEN_W-1:0] run_len;
  logic             run_sat;

  modport master (output run_valid, run_len, run_sat, input run_ready);
  modport slave  (input run_valid, run_len, run_sat, output run_ready);
endinterface

// File: rtl/token_run_encoder_fifo.sv
// Register-based first-word-fall-through FIFO; an extra pointer bit separates full from empty.
module token_run_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while not empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_data = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/token_run_encoder.sv
// Measures runs of '1' tokens on a serial stream and queues one length word per completed run.
module token_run_encoder
  import token_run_pkg::*;
#(
  parameter int LEN_W   = TOKEN_LEN_W,
  parameter int MAX_RUN = TOKEN_MAX_RUN,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  token_run_if.master      run,
  output logic             overflow
);
  if (MAX_RUN < 1 || MAX_RUN > (2**LEN_W) - 1) begin : g_bad_max_run
    $error("token_run_encoder: MAX_RUN out of range for LEN_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("token_run_encoder: DEPTH must be a power of two >= 2");
  end

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_RUN);

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             run_end, push, pop, full, empty;
  logic [LEN_W:0]   head;

  assign run_end = !a && (cnt_q != '0);
  assign pop     = !empty && run.run_ready;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign push    = run_end && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    ovf_d = ovf_q | (run_end && !push);
    if (a) begin
      if (cnt_q < MAX_L) cnt_d = cnt_q + 1'b1;
      else               sat_d = 1'b1;
    end else begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  token_run_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LEN_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({sat_q, cnt_q}),
    .full      (full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty)
  );

  assign run.run_valid = !empty;
  assign run.run_len   = empty ? '0 : head[LEN_W-1:0];
  assign run.run_sat   = !empty && head[LEN_W];
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_token_run_encoder.sv
// Scoreboard bench: a run-counting model predicts words, occupancy and overflow; a monitor checks the DUT.
module tb_token_run_encoder;
  import token_run_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAX   = TOKEN_MAX_RUN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic overflow;

  always #5 clk = ~clk;

  token_run_if #(.LEN_W(TOKEN_LEN_W)) rif ();

  token_run_encoder #(
    .LEN_W   (TOKEN_LEN_W),
    .MAX_RUN (MAX),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .run      (rif),
    .overflow (overflow)
  );

  int passed = 0;
  int total  = 0;

  run_word_t exp_q[$];
  int occ      = 0;   // predicted occupancy after the next edge
  int occ_now  = 0;   // predicted occupancy visible in the current cycle
  bit ovf      = 1'b0;
  bit ovf_now  = 1'b0;
  int run_ones = 0;
  bit clr_pend = 1'b0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    occ_now <= occ;
    ovf_now <= ovf;
    if (clr_pend) begin
      exp_q.delete();
      clr_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", int'(rif.run_valid), int'(occ_now > 0));
      chk("overflow", int'(overflow), int'(ovf_now));
      if (rif.run_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 0, 1);
        end else begin
          chk("len", int'(rif.run_len), int'(exp_q[0].len));
          chk("sat", int'(rif.run_sat), int'(exp_q[0].sat));
          if (rif.run_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("len_idle", int'(rif.run_len), 0);
        chk("sat_idle", int'(rif.run_sat), 0);
      end
    end
  end

  task automatic step(input bit ai, input bit ri);
    bit        pop;
    bit        pushed;
    run_word_t w;
    @(posedge clk);
    #2;
    rst = 1'b0;
    a = ai;
    rif.run_ready = ri;
    pop    = (occ > 0) && ri;
    pushed = 1'b0;
    if (ai) begin
      run_ones++;
    end else if (run_ones > 0) begin
      w.len = TOKEN_LEN_W'((run_ones > MAX) ? MAX : run_ones);
      w.sat = (run_ones > MAX);
      if (occ < DEPTH || pop) begin
        exp_q.push_back(w);
        pushed = 1'b1;
      end else begin
        ovf = 1'b1;
      end
      run_ones = 0;
    end
    occ = occ - int'(pop) + int'(pushed);
  endtask

  task automatic rst_step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    a = 1'b0;
    rif.run_ready = 1'b0;
    run_ones = 0;
    occ = 0;
    ovf = 1'b0;
    clr_pend = 1'b1;
  endtask

  task automatic ones(input int n, input bit ri);
    for (int i = 0; i < n; i++) step(1'b1, ri);
  endtask

  task automatic idle(input int n, input bit ri);
    for (int i = 0; i < n; i++) step(1'b0, ri);
  endtask

  initial begin
    rif.run_ready = 1'b0;
    rst_step();
    rst_step();
    @(posedge clk);
    #2;
    mon_en = 1'b1;

    // single run of three
    step(0, 1); ones(3, 1); idle(2, 1); idle(3, 1);

    // 1 0 1 1 0 1 0
    step(1, 1); step(0, 1); ones(2, 1); step(0, 1); step(1, 1); step(0, 1); idle(3, 1);

    // saturation boundary
    ones(256, 1); step(0, 1); idle(2, 1);
    ones(255, 1); step(0, 1); idle(3, 1);

    // five runs into a blocked four-deep FIFO, hold, then drain
    for (int i = 0; i < 5; i++) begin step(1, 0); step(0, 0); end
    idle(4, 0);
    idle(6, 1);

    // full FIFO with a push on the same edge as a pop
    rst_step();
    for (int i = 0; i < 4; i++) begin step(1, 0); step(0, 0); end
    ones(3, 0); step(0, 1);
    idle(3, 0);
    idle(6, 1);

    // reset mid-run discards the partial run
    ones(10, 1);
    rst_step(); rst_step();
    step(1, 1); step(1, 1); step(0, 1); idle(3, 1);

    // randomized traffic with occasional long runs and rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) rst_step();
      else if ($urandom_range(0, 199) == 0) ones($urandom_range(250, 260), $urandom_range(0, 3) != 0);
      else step($urandom_range(0, 99) < 60, $urandom_range(0, 3) != 0);
    end

    idle(DEPTH + 6, 1);
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
